button_array_debounce: RTL
==========================

BUTTON_ARRAY_DEBOUNCE -- requirements
Module: button_array_debounce

Interface
REQ-001 Parameter CHANNELS, default 5, SHALL set the number of independent button channels (legal range 1..32).
REQ-002 Parameter TICK_DIV, default 250000, SHALL set the sample-tick period in clk cycles (2.5 ms at 100 MHz; legal range >= 1).
REQ-003 Parameter STABLE_CNT, default 3, SHALL set the number of consecutive differing samples needed to accept a change (legal range >= 1).
REQ-004 Parameter REPEAT_DELAY, default 200, SHALL set the number of ticks from press acceptance to the first repeat pulse.
REQ-005 Parameter REPEAT_RATE, default 40, SHALL set the number of ticks between subsequent repeat pulses.
REQ-006 Port clk, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-007 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-008 Port btn_in, input, CHANNELS bits, SHALL carry the raw asynchronous button inputs.
REQ-009 Port btn_level, output, CHANNELS bits, SHALL carry the debounced level per channel.
REQ-010 Port btn_press, output, CHANNELS bits, SHALL carry a one-cycle pulse on accepted 0->1 transitions.
REQ-011 Port btn_release, output, CHANNELS bits, SHALL carry a one-cycle pulse on accepted 1->0 transitions.
REQ-012 Port btn_repeat, output, CHANNELS bits, SHALL carry a one-cycle auto-repeat pulse while a button is held.

Function
REQ-013 Each btn_in bit SHALL pass through a two-flop synchroniser before any other logic.
REQ-014 The shared tick counter SHALL run 0..TICK_DIV-1 and wrap, asserting tick for exactly one cycle when the count is TICK_DIV-1; TICK_DIV=1 SHALL give a tick every cycle.
REQ-015 Each channel SHALL implement a four-state FSM: RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE; state changes SHALL occur only on tick cycles.
REQ-016 On a tick in RELEASED or PRESSED, a synchronised sample differing from btn_level SHALL move the channel to the matching CONFIRM state with its stability count set to 1.
REQ-017 On a tick in a CONFIRM state, a differing sample SHALL increment the count; a matching sample SHALL return the channel to the stable state with the count cleared, and no pulse SHALL be emitted.
REQ-018 When the count reaches STABLE_CNT, btn_level SHALL toggle in the next cycle and btn_press or btn_release SHALL pulse in that same cycle; the count SHALL clear.
REQ-019 With STABLE_CNT=1, acceptance SHALL occur on the first differing tick; the CONFIRM state is transient.
REQ-020 The latency from a btn_in edge to the btn_level change SHALL be at most 3 + STABLE_CNT*TICK_DIV cycles and at least 3 + (STABLE_CNT-1)*TICK_DIV cycles.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce pulses in the same cycle.
REQ-022 The stability counter SHALL be $clog2(STABLE_CNT+1) bits wide and the tick counter $clog2(TICK_DIV) bits wide (minimum 1); neither SHALL overflow.

Reset
REQ-023 While rst=1, all outputs, synchroniser flops, counters and FSMs SHALL be 0/RELEASED, asynchronously and immediately.
REQ-024 A reset during a CONFIRM state SHALL discard the partial count; a button held through reset SHALL produce btn_press only after a full new confirmation.
REQ-025 The tick counter SHALL restart at 0 on reset release.

Configuration
REQ-026 With macro BTN_AUTOREPEAT_EN defined, each channel in PRESSED SHALL count ticks, pulse btn_repeat REPEAT_DELAY ticks after press acceptance and then every REPEAT_RATE ticks.
REQ-027 With BTN_AUTOREPEAT_EN defined, the repeat counter SHALL clear whenever the channel is not in PRESSED, and a repeat pulse SHALL never coincide with btn_press.
REQ-028 Without BTN_AUTOREPEAT_EN, no repeat counters SHALL be built and btn_repeat SHALL be constant 0.

Verification (CHANNELS=4, TICK_DIV=4, STABLE_CNT=3)
REQ-029 Clean press: btn_in[0]=1 held for 40 cycles -> exactly one btn_press[0] pulse, with btn_level[0]=1 within 15 cycles.
REQ-030 Bounce: btn_in[1] toggled every 3 cycles for 30 cycles, then held at 0 -> no btn_press[1], and btn_level[1] stays 0.
REQ-031 Simultaneous: btn_in[2] and btn_in[3] rise in the same cycle -> btn_press[2] and btn_press[3] pulse in the same cycle, once each.
REQ-032 Release: btn_in[0] falls after an accepted press -> one btn_release[0] pulse, btn_level[0]=0 within 15 cycles, and no btn_press.
REQ-033 Reset mid-confirm: rst=1 for 2 cycles after 2 differing ticks on ch0, with btn_in[0] held at 1 -> outputs 0 during reset, then btn_press[0] occurs only after 3 further ticks.
REQ-034 Auto-repeat (macro defined, REPEAT_DELAY=5, REPEAT_RATE=2): hold ch1 -> btn_repeat[1] pulses 5, 7 and 9 ticks after btn_press[1]; with the macro undefined, btn_repeat stays 0.

Source files
------------

// File: rtl/button_array_debounce.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : button_array_debounce
//  Description : Multi-channel push-button debouncer with shared sample tick,
//                per-channel press/release pulses and optional auto-repeat
//                (enabled by defining BTN_AUTOREPEAT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module button_array_debounce #(
    parameter int CHANNELS     = 5,
    parameter int TICK_DIV     = 250000,
    parameter int STABLE_CNT   = 3,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_STB_W  = $clog2(STABLE_CNT + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_STB_W-1:0]  c_STB_ONE   = c_STB_W'(1);
    localparam logic [c_STB_W-1:0]  c_STB_DONE  = c_STB_W'(STABLE_CNT);

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } state_t;

    // Elaboration-time guards against illegal parameterisations.
    generate
        if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
            $error("button_array_debounce: CHANNELS must be 1..32");
        end
        if (TICK_DIV < 1) begin : g_bad_tick_div
            $error("button_array_debounce: TICK_DIV must be >= 1");
        end
        if (STABLE_CNT < 1) begin : g_bad_stable_cnt
            $error("button_array_debounce: STABLE_CNT must be >= 1");
        end
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
            $error("button_array_debounce: REPEAT_DELAY and REPEAT_RATE must be >= 1");
        end
    endgenerate

    // Two-flop synchroniser on every raw input.
    logic [CHANNELS-1:0] r_sync_meta;
    logic [CHANNELS-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= btn_in;
            r_sync      <= r_sync_meta;
        end
    end

    // Shared sample tick: one cycle in every TICK_DIV.
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            state_t             r_state;
            state_t             w_state_nxt;
            logic [c_STB_W-1:0] r_cnt;
            logic [c_STB_W-1:0] w_cnt_nxt;
            logic [c_STB_W-1:0] w_cnt_inc;
            logic               r_level;
            logic               r_press;
            logic               r_release;
            logic               w_level_nxt;
            logic               w_press_nxt;
            logic               w_release_nxt;
            logic               w_diff;
            logic               w_accept;

            assign w_diff    = r_sync[i] ^ r_level;
            assign w_cnt_inc = r_cnt + 1'b1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state   <= RELEASED;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_cnt     <= w_cnt_nxt;
                    r_level   <= w_level_nxt;
                    r_press   <= w_press_nxt;
                    r_release <= w_release_nxt;
                end
            end

            always_comb begin
                w_state_nxt   = r_state;
                w_cnt_nxt     = r_cnt;
                w_level_nxt   = r_level;
                w_press_nxt   = 1'b0;
                w_release_nxt = 1'b0;
                w_accept      = 1'b0;
                if (w_tick) begin
                    unique case (r_state)
                        RELEASED, PRESSED: begin
                            if (w_diff) begin
                                w_state_nxt = (r_state == RELEASED) ? CONFIRM_PRESS : CONFIRM_RELEASE;
                                w_cnt_nxt   = c_STB_ONE;
                                w_accept    = (c_STB_ONE == c_STB_DONE);
                            end
                        end
                        CONFIRM_PRESS, CONFIRM_RELEASE: begin
                            if (w_diff) begin
                                w_cnt_nxt = w_cnt_inc;
                                w_accept  = (w_cnt_inc == c_STB_DONE);
                            end else begin
                                w_state_nxt = (r_state == CONFIRM_PRESS) ? RELEASED : PRESSED;
                                w_cnt_nxt   = '0;
                            end
                        end
                    endcase
                    // Acceptance overrides the confirm bookkeeping above.
                    if (w_accept) begin
                        w_state_nxt   = r_level ? RELEASED : PRESSED;
                        w_cnt_nxt     = '0;
                        w_level_nxt   = ~r_level;
                        w_press_nxt   = ~r_level;
                        w_release_nxt = r_level;
                    end
                end
            end

            assign btn_level[i]   = r_level;
            assign btn_press[i]   = r_press;
            assign btn_release[i] = r_release;

`ifdef BTN_AUTOREPEAT_EN
            localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
            localparam logic [c_REP_W-1:0] c_REP_FIRST = c_REP_W'(REPEAT_DELAY);
            localparam logic [c_REP_W-1:0] c_REP_NEXT  = c_REP_W'(REPEAT_RATE);

            logic [c_REP_W-1:0] r_rep_cnt;
            logic [c_REP_W-1:0] w_rep_inc;
            logic [c_REP_W-1:0] w_rep_target;
            logic               r_rep_seen;
            logic               r_repeat;

            assign w_rep_inc    = r_rep_cnt + 1'b1;
            assign w_rep_target = r_rep_seen ? c_REP_NEXT : c_REP_FIRST;

            // Counting starts on the first tick spent in PRESSED, so a repeat
            // can never land in the same cycle as the press pulse.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rep_cnt  <= '0;
                    r_rep_seen <= 1'b0;
                    r_repeat   <= 1'b0;
                end else begin
                    r_repeat <= 1'b0;
                    if (r_state != PRESSED) begin
                        r_rep_cnt  <= '0;
                        r_rep_seen <= 1'b0;
                    end else if (w_tick) begin
                        if (w_rep_inc == w_rep_target) begin
                            r_rep_cnt  <= '0;
                            r_rep_seen <= 1'b1;
                            r_repeat   <= 1'b1;
                        end else begin
                            r_rep_cnt <= w_rep_inc;
                        end
                    end
                end
            end

            assign btn_repeat[i] = r_repeat;
`else
            assign btn_repeat[i] = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire
